// File: rtl/r5p_gpr_bank.sv
// Multi-hart GPR bank: NRP zero-latency read ports, one write port, x0 hardwired to zero.
// Writes land on the next edge; after reset every bank is zeroed while busy is high, and no backpressure applies otherwise.
module r5p_gpr_bank #(
  parameter int AW    = 5,
  parameter int XLEN  = 32,
  parameter int NRP   = 2,
  parameter int HARTS = 1,
  parameter bit WBYP  = 1'b0,
  parameter bit RCLR  = 1'b1,
  localparam int HW   = (HARTS > 1) ? $clog2(HARTS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRP-1:0]      e_rs,
  input  logic [NRP*HW-1:0]   h_rs,
  input  logic [NRP*AW-1:0]   a_rs,
  output logic [NRP*XLEN-1:0] d_rs,
  input  logic                e_rd,
  input  logic [HW-1:0]       h_rd,
  input  logic [AW-1:0]       a_rd,
  input  logic [XLEN-1:0]     d_rd,
  output logic                busy
);

  localparam int IW    = (HARTS > 1) ? HW + AW : AW;
  localparam int DEPTH = HARTS << AW;

  logic [XLEN-1:0]   mem [DEPTH];
  logic [IW-1:0]     w_idx;
  logic [NRP*IW-1:0] r_idx;
  logic [IW-1:0]     cnt;
  logic              clr_we;
  logic              wen;

  // Reads are never gated by the enables; they only document intent upstream.
  wire unused_e_rs = &{1'b0, e_rs};

  assign wen = e_rd & (|a_rd) & ~busy;

  generate
    if (HARTS > 1) begin : g_multi
      assign w_idx = {h_rd, a_rd};
      for (genvar i = 0; i < NRP; i++) begin : g_ridx
        assign r_idx[i*IW +: IW] = {h_rs[i*HW +: HW], a_rs[i*AW +: AW]};
      end
    end else begin : g_single
      wire unused_h = &{1'b0, h_rd, h_rs};
      assign w_idx = a_rd;
      assign r_idx = a_rs;
    end
  endgenerate

  generate
    if (RCLR) begin : g_clr
      typedef enum logic {CLR, RDY} state_t;
      state_t        state_q, state_d;
      logic [IW-1:0] cnt_q, cnt_d;

      always_ff @(posedge clk) begin
        if (rst) begin
          state_q <= CLR;
          cnt_q   <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
        end
      end

      // Counter parks on the last index instead of wrapping when the sweep ends.
      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == CLR) begin
          if (cnt_q == IW'(DEPTH - 1)) state_d = RDY;
          else                         cnt_d   = cnt_q + 1'b1;
        end
      end

      assign busy   = rst | (state_q == CLR);
      assign clr_we = (state_q == CLR) & ~rst;
      assign cnt    = cnt_q;
    end else begin : g_noclr
      wire unused_rst = &{1'b0, rst};
      assign busy   = 1'b0;
      assign clr_we = 1'b0;
      assign cnt    = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (clr_we)   mem[cnt]   <= '0;
    else if (wen) mem[w_idx] <= d_rd;
  end

  generate
    for (genvar i = 0; i < NRP; i++) begin : g_rd
      logic [IW-1:0]   ri;
      logic [AW-1:0]   ra;
      logic [XLEN-1:0] rdat;

      assign ri = r_idx[i*IW +: IW];
      assign ra = a_rs[i*AW +: AW];

      always_comb begin
        rdat = mem[ri];
        if (WBYP && wen && (ri == w_idx)) rdat = d_rd;
        if (busy || (ra == '0))           rdat = '0;
      end

      assign d_rs[i*XLEN +: XLEN] = rdat;
    end
  endgenerate

endmodule

// File: tb/tb_r5p_gpr_bank.sv
// Bench for r5p_gpr_bank: a 4-hart 3-port bypassing instance and a 1-hart 2-port non-bypassing instance.
module tb_r5p_gpr_bank;

  logic        clk = 1'b0;
  logic        rst;

  // main instance: AW=5, NRP=3, HARTS=4, WBYP=1
  logic [2:0]  e_rs;
  logic [5:0]  h_rs;
  logic [14:0] a_rs;
  wire  [95:0] d_rs;
  logic        e_rd;
  logic [1:0]  h_rd;
  logic [4:0]  a_rd;
  logic [31:0] d_rd;
  wire         busy;

  // small instance: AW=5, NRP=2, HARTS=1, WBYP=0
  logic [1:0]  s_e_rs;
  logic [1:0]  s_h_rs;
  logic [9:0]  s_a_rs;
  wire  [63:0] s_d_rs;
  logic        s_e_rd;
  logic        s_h_rd;
  logic [4:0]  s_a_rd;
  logic [31:0] s_d_rd;
  wire         s_busy;

  r5p_gpr_bank #(.AW(5), .XLEN(32), .NRP(3), .HARTS(4), .WBYP(1'b1), .RCLR(1'b1)) dut (
    .clk(clk), .rst(rst), .e_rs(e_rs), .h_rs(h_rs), .a_rs(a_rs), .d_rs(d_rs),
    .e_rd(e_rd), .h_rd(h_rd), .a_rd(a_rd), .d_rd(d_rd), .busy(busy));

  r5p_gpr_bank #(.AW(5), .XLEN(32), .NRP(2), .HARTS(1), .WBYP(1'b0), .RCLR(1'b1)) dut_s (
    .clk(clk), .rst(rst), .e_rs(s_e_rs), .h_rs(s_h_rs), .a_rs(s_a_rs), .d_rs(s_d_rs),
    .e_rd(s_e_rd), .h_rd(s_h_rd), .a_rd(s_a_rd), .d_rd(s_d_rd), .busy(s_busy));

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  typedef struct {
    logic            we;
    logic [1:0]      hw;
    logic [4:0]      aw;
    logic [31:0]     dw;
    logic [2:0][1:0] hr;
    logic [2:0][4:0] ar;
    logic [2:0][31:0] ex;
  } vec_t;

  int          n_vec = 0;
  int          n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ref_mem [128];
  bit          mbusy = 1'b1;
  int          mcnt  = 0;
  logic        last_busy, last_sbusy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] hw, input logic [4:0] aw,
                              input logic [31:0] dw,
                              input logic [1:0] h0, input logic [4:0] a0,
                              input logic [1:0] h1, input logic [4:0] a1,
                              input logic [1:0] h2, input logic [4:0] a2,
                              input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    vec_t v;
    v.we = we; v.hw = hw; v.aw = aw; v.dw = dw;
    v.hr[0] = h0; v.ar[0] = a0; v.ex[0] = e0;
    v.hr[1] = h1; v.ar[1] = a1; v.ex[1] = e1;
    v.hr[2] = h2; v.ar[2] = a2; v.ex[2] = e2;
    return v;
  endfunction

  function automatic logic [31:0] model_rd(input logic [1:0] h, input logic [4:0] a);
    if (rst || mbusy) return 32'h0;
    if (a == 5'd0) return 32'h0;
    if (e_rd && a_rd != 5'd0 && h_rd == h && a_rd == a) return d_rd;
    return ref_mem[int'(h) * 32 + int'(a)];
  endfunction

  task automatic model_clk();
    if (rst) begin
      mbusy = 1'b1;
      mcnt  = 0;
    end else if (mbusy) begin
      ref_mem[mcnt] = 32'h0;
      if (mcnt == 127) mbusy = 1'b0;
      else             mcnt++;
    end else if (e_rd && a_rd != 5'd0) begin
      ref_mem[int'(h_rd) * 32 + int'(a_rd)] = d_rd;
    end
  endtask

  // One cycle on the main instance; expected data from the table or the model.
  task automatic step(input vec_t v, input bit use_model, input string nm);
    logic [31:0] e;
    e_rd = v.we; h_rd = v.hw; a_rd = v.aw; d_rd = v.dw;
    for (int i = 0; i < 3; i++) begin
      h_rs[i*2 +: 2] = v.hr[i];
      a_rs[i*5 +: 5] = v.ar[i];
    end
    for (int i = 0; i < 3; i++)
      exp_q.push_back(use_model ? model_rd(v.hr[i], v.ar[i]) : v.ex[i]);
    @(negedge clk);
    last_busy  = busy;
    last_sbusy = s_busy;
    for (int i = 0; i < 3; i++) begin
      e = exp_q.pop_front();
      chk($sformatf("%s port%0d", nm, i), d_rs[i*32 +: 32], e);
    end
    chk({nm, " busy"}, {31'h0, busy}, {31'h0, rst | mbusy});
    @(posedge clk);
    model_clk();
    #1;
  endtask

  task automatic s_cyc(input logic we, input logic hw, input logic [4:0] aw, input logic [31:0] dw,
                       input logic [4:0] a0, input logic [4:0] a1,
                       input logic [31:0] e0, input logic [31:0] e1, input string nm);
    s_e_rd = we; s_h_rd = hw; s_a_rd = aw; s_d_rd = dw;
    s_h_rs = {hw, ~hw};
    s_a_rs = {a1, a0};
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    @(negedge clk);
    chk({nm, " s_port0"}, s_d_rs[31:0],  exp_q.pop_front());
    chk({nm, " s_port1"}, s_d_rs[63:32], exp_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [11];
  vec_t idle, v;
  int   n, sn;

  initial begin
    idle = mk(1'b0, 2'd0, 5'd0, 32'h0, 2'd1, 5'd3, 2'd0, 5'd1, 2'd3, 5'd31, 32'h0, 32'h0, 32'h0);

    tbl[0]  = mk(1, 2, 5,  32'hDEADBEEF, 2, 5,  1, 5,  2, 5,  32'hDEADBEEF, 32'h0, 32'hDEADBEEF);
    tbl[1]  = mk(0, 0, 0,  32'h0,        2, 5,  1, 5,  3, 5,  32'hDEADBEEF, 32'h0, 32'h0);
    tbl[2]  = mk(1, 0, 7,  32'h12345678, 0, 7,  0, 6,  0, 7,  32'h12345678, 32'h0, 32'h12345678);
    tbl[3]  = mk(1, 0, 0,  32'hFFFFFFFF, 0, 0,  1, 0,  0, 7,  32'h0, 32'h0, 32'h12345678);
    tbl[4]  = mk(1, 3, 0,  32'hFFFFFFFF, 3, 0,  3, 0,  3, 0,  32'h0, 32'h0, 32'h0);
    tbl[5]  = mk(0, 0, 0,  32'h0,        0, 0,  3, 0,  2, 5,  32'h0, 32'h0, 32'hDEADBEEF);
    tbl[6]  = mk(0, 1, 5,  32'h55555555, 1, 5,  1, 5,  1, 5,  32'h0, 32'h0, 32'h0);
    tbl[7]  = mk(0, 0, 0,  32'h0,        1, 5,  0, 7,  2, 5,  32'h0, 32'h12345678, 32'hDEADBEEF);
    tbl[8]  = mk(1, 1, 31, 32'hA5A5A5A5, 1, 31, 0, 31, 2, 31, 32'hA5A5A5A5, 32'h0, 32'h0);
    tbl[9]  = mk(1, 1, 31, 32'h0F0F0F0F, 1, 31, 1, 31, 0, 7,  32'h0F0F0F0F, 32'h0F0F0F0F, 32'h12345678);
    tbl[10] = mk(0, 0, 0,  32'h0,        1, 31, 3, 31, 2, 5,  32'h0F0F0F0F, 32'h0, 32'hDEADBEEF);

    rst = 1'b1;
    e_rs = '1; h_rs = '0; a_rs = '0; e_rd = 1'b0; h_rd = '0; a_rd = '0; d_rd = '0;
    s_e_rs = '1; s_h_rs = '0; s_a_rs = '0; s_e_rd = 1'b0; s_h_rd = 1'b0; s_a_rd = '0; s_d_rd = '0;
    @(posedge clk);
    #1;

    // reset state, then clear durations of both banks
    step(idle, 1'b1, "reset");
    chk("reset s_busy", {31'h0, last_sbusy}, 32'h1);
    chk("reset s_d_rs", s_d_rs[31:0] | s_d_rs[63:32], 32'h0);
    rst = 1'b0;
    n = 0; sn = 0;
    for (int k = 0; k < 1000; k++) begin
      step(idle, 1'b1, "clear");
      if (last_sbusy) sn++;
      if (!last_busy) break;
      n++;
    end
    chk("clear_len main", n, 32'd128);
    chk("clear_len small", sn, 32'd32);

    for (int k = 0; k < 16; k++)
      s_cyc(0, 0, 5'd0, 32'h0, 5'(2*k), 5'(2*k+1), 32'h0, 32'h0, "clr_scan");
    s_cyc(1, 0, 5'd7,  32'h12345678, 5'd7,  5'd7,  32'h0,        32'h0,        "nobyp_old");
    s_cyc(0, 0, 5'd0,  32'h0,        5'd7,  5'd6,  32'h12345678, 32'h0,        "after_wr");
    s_cyc(1, 1, 5'd7,  32'hAAAA5555, 5'd7,  5'd7,  32'h12345678, 32'h12345678, "nobyp_old2");
    s_cyc(1, 1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd7,  32'h0,        32'hAAAA5555, "wr_a0");
    s_cyc(0, 0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        "a0_zero");
    s_cyc(1, 1, 5'd31, 32'h0BADF00D, 5'd31, 5'd0,  32'h0,        32'h0,        "h_wr");
    s_cyc(0, 0, 5'd0,  32'h0,        5'd31, 5'd31, 32'h0BADF00D, 32'h0BADF00D, "h_ignored");
    s_e_rd = 1'b0;

    for (int k = 0; k < 11; k++)
      step(tbl[k], 1'b0, $sformatf("tbl%0d", k));

    // restart of the clear mid-sweep; a write issued during the sweep must be lost
    rst = 1'b1;
    step(idle, 1'b1, "rst2");
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      v = idle;
      if (c == 10) v = mk(1, 1, 3, 32'hCAFEF00D, 1, 3, 1, 3, 0, 0, 0, 0, 0);
      step(v, 1'b1, "clr_a");
    end
    rst = 1'b1;
    step(idle, 1'b1, "rst3");
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 1000; k++) begin
      step(idle, 1'b1, "clr_b");
      if (!last_busy) break;
      n++;
    end
    chk("restart clear_len", n, 32'd128);
    step(mk(0, 0, 0, 32'h0, 1, 3, 1, 3, 1, 3, 32'h0, 32'h0, 32'h0), 1'b0, "lost_wr");

    for (int k = 0; k < 10000; k++) begin
      v.we = 1'($urandom_range(0, 1));
      v.hw = 2'($urandom);
      v.aw = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
      v.dw = $urandom;
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          v.hr[i] = v.hw;
          v.ar[i] = v.aw;
        end else begin
          v.hr[i] = 2'($urandom);
          v.ar[i] = 5'($urandom_range(0, 31));
        end
        v.ex[i] = 32'h0;
      end
      step(v, 1'b1, "rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/r5p_gpr_bank.md
R5P_GPR_BANK -- requirements
Module: r5p_gpr_bank

Interface
REQ-001 Parameter AW, default 5, register address width (4 for RV32E).
REQ-002 Parameter XLEN, default 32, register data width.
REQ-003 Parameter NRP, default 2, number of read ports (1..4).
REQ-004 Parameter HARTS, default 1, number of register banks (power of two, 1..8); HW = max(1, clog2(HARTS)).
REQ-005 Parameter WBYP, default 1'b0, write-to-read bypass enable.
REQ-006 Parameter RCLR, default 1'b1, hardware clear of all banks after reset.
REQ-007 clk  input  1  clock; single clock domain, all state on rising edge.
REQ-008 rst  input  1  reset, synchronous, active-high.
REQ-009 e_rs  input  NRP  per-port read enable (informational; reads are not gated).
REQ-010 h_rs  input  NRP*HW  per-port bank select.
REQ-011 a_rs  input  NRP*AW  per-port read address.
REQ-012 d_rs  output  NRP*XLEN  per-port read data, combinational.
REQ-013 e_rd  input  1  write enable.
REQ-014 h_rd  input  HW  write bank select.
REQ-015 a_rd  input  AW  write address.
REQ-016 d_rd  input  XLEN  write data.
REQ-017 busy  output  1  clear in progress; writes dropped, reads return 0.

Function
REQ-018 Storage: HARTS*2**AW entries of XLEN bits, index {h,a}.
REQ-019 Effective write wen = e_rd & |a_rd & ~busy; entry {h_rd,a_rd} updated on the next rising edge.
REQ-020 Address 0 of every bank reads 0 on every port, regardless of storage contents or bypass.
REQ-021 Read port i returns entry {h_rs[i],a_rs[i]} combinationally (zero latency); ports are independent and may address the same entry.
REQ-022 WBYP=1: port i returns d_rd when wen & h_rd==h_rs[i] & a_rd==a_rs[i]; otherwise stored value.
REQ-023 WBYP=0: read of an entry being written in the same cycle returns the old value.
REQ-024 Clear FSM states: CLR, RDY.
REQ-025 RCLR=1: rst forces state CLR and clear counter cnt=0; in CLR, each cycle entry cnt is written 0 and cnt increments; entry HARTS*2**AW-1 written -> state RDY.
REQ-026 Clear duration is exactly HARTS*2**AW cycles after rst deasserts; busy=1 throughout, 0 from the first RDY cycle.
REQ-027 Counter width clog2(HARTS*2**AW); no wrap occurs because the FSM exits on the last index.
REQ-028 rst asserted mid-clear restarts cnt at 0 and holds CLR.
REQ-029 External writes during CLR are discarded (not queued); reads during CLR return 0 on all ports.
REQ-030 RCLR=0: no clear FSM; busy constant 0; storage not initialised except via REQ-020.
REQ-031 HARTS=1: h_rs/h_rd are ignored.

Reset
REQ-032 During rst=1: busy=1 if RCLR=1, else 0; d_rs=0 on all ports if RCLR=1.
REQ-033 Stored data is not reset by rst except via the clear sequence; state=CLR, cnt=0 held while rst=1.

Verification
REQ-034 Defaults, RCLR=1: pulse rst 1 cycle -> busy=1 for exactly 32 cycles, then 0; all 32 entries read 0.
REQ-035 HARTS=4: write 0xDEADBEEF to h=2,a=5 -> next cycle port0 h=2,a=5 reads 0xDEADBEEF; port1 h=1,a=5 reads 0.
REQ-036 WBYP=1, NRP=3: write 0x12345678 to a=7 while ports 0,2 read a=7 -> same cycle both read 0x12345678; WBYP=0 -> old value.
REQ-037 Write 0xFFFFFFFF to a=0 in any bank -> all ports reading a=0 return 0.
REQ-038 HARTS=2: rst re-asserted at clear cycle 20 -> busy stays 1 for 64 further cycles; write issued at cycle 10 of clear is lost (entry reads 0 afterwards).
REQ-039 Random writes/reads on all ports for 10k cycles vs. reference model -> zero mismatches.
